// File: rtl/hms_uptime_pkg.sv
// hms_uptime_pkg: shared types, constants and BCD helpers for the uptime counter.
//   bcd2_t     : two-digit packed BCD ([7:4] tens, [3:0] units)
//   bcd2_valid : both nibbles are decimal digits and tens <= max_tens
//   bcd2_inc   : BCD +1, returns {carry, next}; carry set on 99 -> 00
package hms_uptime_pkg;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t C_BCD_59 = 8'h59;
   localparam bcd2_t C_BCD_00 = 8'h00;

   function automatic logic bcd2_valid(input bcd2_t value, input logic [3:0] max_tens);
      return (value[3:0] <= 4'd9) && (value[7:4] <= max_tens);
   endfunction

   function automatic logic [8:0] bcd2_inc(input bcd2_t value);
      logic [3:0] tens;
      logic [3:0] units;
      logic       carry;
      tens  = value[7:4];
      units = value[3:0];
      carry = 1'b0;
      if (units == 4'd9) begin
         units = 4'd0;
         if (tens == 4'd9) begin
            tens  = 4'd0;
            carry = 1'b1;
         end else begin
            tens = tens + 4'd1;
         end
      end else begin
         units = units + 4'd1;
      end
      return {carry, tens, units};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that wraps from max to 00.
//   CLK, RST_N : clock, async active-low reset
//   clr        : synchronous clear to 00 (highest priority)
//   load       : load load_val
//   inc        : count up by one
//   max        : highest value before wrapping to 00
//   val        : current value
//   carry_out  : combinational, inc && val == max
module bcd_mod_counter
   import hms_uptime_pkg::*;
(
   input  logic  CLK,
   input  logic  RST_N,
   input  logic  clr,
   input  logic  load,
   input  bcd2_t load_val,
   input  logic  inc,
   input  bcd2_t max,
   output bcd2_t val,
   output logic  carry_out
);

   logic [8:0] inc_res;
   bcd2_t      val_d;

   always_comb begin
      inc_res = bcd2_inc(val);
      val_d   = val;
      if (clr) begin
         val_d = C_BCD_00;
      end else if (load) begin
         val_d = load_val;
      end else if (inc) begin
         // Overflow past 99 also lands on 00.
         val_d = ((val == max) || inc_res[8]) ? C_BCD_00 : inc_res[7:0];
      end
   end

   assign carry_out = inc && (val == max);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         val <= C_BCD_00;
      end else begin
         val <= val_d;
      end
   end

endmodule

// File: rtl/hms_uptime_counter.sv
// hms_uptime_counter: counts rising edges of a 1 s toggle as hours:minutes:seconds in BCD.
//   CLK, RST_N                    : clock, async active-low reset
//   TIMER_IN                      : 1 s toggle, each rising edge is one second
//   CLR / HOLD / LOAD             : clear time+alarm / drop ticks / load time
//   LOAD_SEC, LOAD_MIN, LOAD_HOUR : BCD load values
//   ALARM_EN, ALARM_MIN/HOUR      : alarm enable and BCD match time
//   ALARM_ACK                     : clear sticky alarm
//   SEC, MIN, HOUR                : BCD time
//   SEC_PLS                       : one-cycle pulse per detected second (even when held)
//   ALARM                         : sticky alarm flag
//   LOAD_ERR                      : one-cycle pulse after a rejected LOAD
module hms_uptime_counter
   import hms_uptime_pkg::*;
#(
   parameter int unsigned P_SYNC     = 1,
   parameter int unsigned P_HOUR_MAX = 99
) (
   input  logic  CLK,
   input  logic  RST_N,
   input  logic  TIMER_IN,
   input  logic  CLR,
   input  logic  HOLD,
   input  logic  LOAD,
   input  bcd2_t LOAD_SEC,
   input  bcd2_t LOAD_MIN,
   input  bcd2_t LOAD_HOUR,
   input  logic  ALARM_EN,
   input  bcd2_t ALARM_MIN,
   input  bcd2_t ALARM_HOUR,
   input  logic  ALARM_ACK,
   output bcd2_t SEC,
   output bcd2_t MIN,
   output bcd2_t HOUR,
   output logic  SEC_PLS,
   output logic  ALARM,
   output logic  LOAD_ERR
);

   localparam bcd2_t C_HOUR_MAX = {4'(P_HOUR_MAX / 10), 4'(P_HOUR_MAX % 10)};

   logic s, p, tick;

   // Synchronizer and previous-sample reset high so a level already high at
   // reset release is never mistaken for a rising edge.
   if (P_SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            sync_q <= 2'b11;
         end else begin
            sync_q <= {sync_q[0], TIMER_IN};
         end
      end
      assign s = sync_q[1];
   end else begin : g_nosync
      assign s = TIMER_IN;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p <= 1'b1;
      end else begin
         p <= s;
      end
   end

   assign tick = s & ~p;

   logic load_valid, load_ok, sec_inc;
   logic sec_carry, min_carry, hour_carry;

   // BCD values compare in numeric order once both nibbles are digits.
   assign load_valid = bcd2_valid(LOAD_SEC, 4'd5) && bcd2_valid(LOAD_MIN, 4'd5) &&
                       bcd2_valid(LOAD_HOUR, 4'd9) && (LOAD_HOUR <= C_HOUR_MAX);
   assign load_ok    = LOAD && !CLR && load_valid;
   // Any LOAD, even a rejected one, swallows a coincident tick.
   assign sec_inc    = tick && !HOLD && !CLR && !LOAD;

   bcd_mod_counter u_sec (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .clr       (CLR),
      .load      (load_ok),
      .load_val  (LOAD_SEC),
      .inc       (sec_inc),
      .max       (C_BCD_59),
      .val       (SEC),
      .carry_out (sec_carry)
   );

   bcd_mod_counter u_min (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .clr       (CLR),
      .load      (load_ok),
      .load_val  (LOAD_MIN),
      .inc       (sec_carry),
      .max       (C_BCD_59),
      .val       (MIN),
      .carry_out (min_carry)
   );

   bcd_mod_counter u_hour (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .clr       (CLR),
      .load      (load_ok),
      .load_val  (LOAD_HOUR),
      .inc       (min_carry),
      .max       (C_HOUR_MAX),
      .val       (HOUR),
      .carry_out (hour_carry)
   );

   // Post-tick minute/hour, only meaningful when sec_carry (new SEC == 00).
   logic [8:0] min_inc, hour_inc;
   bcd2_t      new_min, new_hour;
   logic       alarm_set, alarm_d;

   always_comb begin
      min_inc  = bcd2_inc(MIN);
      hour_inc = bcd2_inc(HOUR);
      new_min  = (min_carry || min_inc[8]) ? C_BCD_00 : min_inc[7:0];
      new_hour = HOUR;
      if (min_carry) begin
         new_hour = (hour_carry || hour_inc[8]) ? C_BCD_00 : hour_inc[7:0];
      end
      alarm_set = ALARM_EN && sec_carry && (new_min == ALARM_MIN) && (new_hour == ALARM_HOUR);
      alarm_d   = ALARM;
      if (CLR) begin
         alarm_d = 1'b0;
      end else if (alarm_set) begin
         alarm_d = 1'b1;
      end else if (ALARM_ACK) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SEC_PLS  <= 1'b0;
         ALARM    <= 1'b0;
         LOAD_ERR <= 1'b0;
      end else begin
         SEC_PLS  <= tick;
         ALARM    <= alarm_d;
         LOAD_ERR <= LOAD && !CLR && !load_valid;
      end
   end

endmodule
